// File: rtl/mux2to1_pkg.sv
// Shared types and limits for the mux2to1 slice.
package mux2to1_pkg;

  // Legal data width range for mux2to1 and mux2to1_cell.
  localparam int unsigned MUX_MIN_WIDTH = 1;
  localparam int unsigned MUX_MAX_WIDTH = 64;

  // Meaning of the sel input.
  typedef enum logic {
    SEL_IN0 = 1'b0,
    SEL_IN1 = 1'b1
  } sel_e;

endpackage : mux2to1_pkg

// File: rtl/mux2to1_cell.sv
// Combinational WIDTH-bit 2:1 selector.
// Ports: in1/in0 - data inputs, sel - 1 picks in1 / 0 picks in0, y - selected data.
module mux2to1_cell
  import mux2to1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in0,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // Every bit follows the same select; a non-0/1 sel is a don't-care.
  always_comb begin
    y = in0;
    if (sel_e'(sel) == SEL_IN1) begin
      y = in1;
    end
  end

endmodule : mux2to1_cell

// File: rtl/mux2to1.sv
// 2:1 data selector with optional output register and valid qualifier.
// Ports: in1/in0 - data, sel - select (1 -> in1), out - selected data,
//        clk/rst_n - clock and async active-low reset, in_valid - input qualifier,
//        out_valid - out holds a valid selection.
module mux2to1
  import mux2to1_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in0,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             out_valid
);

  // Elaboration-time width guard.
  if ((WIDTH < MUX_MIN_WIDTH) || (WIDTH > MUX_MAX_WIDTH)) begin : g_width_check
    $error("mux2to1: WIDTH must be in 1..64");
  end

  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_d;
  logic             out_valid_q;

  mux2to1_cell #(
    .WIDTH (WIDTH)
  ) u_cell (
    .in1 (in1),
    .in0 (in0),
    .sel (sel),
    .y   (mux_y)
  );

  // Capture on valid input; otherwise hold data and drop valid.
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_d       = mux_y;
      out_valid_d = 1'b1;
    end
  end

  // Output register; reset clears any in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= WIDTH'(0);
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // REG_OUT=0 bypasses the register; valid is still gated by reset.
  assign out       = REG_OUT ? out_q : mux_y;
  assign out_valid = REG_OUT ? out_valid_q : (in_valid & rst_n);

endmodule : mux2to1

// File: tb/tb_mux2to1.sv
// Self-checking bench for mux2to1: 1-bit and 8-bit registered instances plus
// an 8-bit combinational instance, all fed from the same inputs.
module tb_mux2to1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in1;
  logic [7:0] in0;
  logic       sel;
  logic       in_valid;

  logic       w1_out;
  logic       w1_ov;
  logic [7:0] w8_out;
  logic       w8_ov;
  logic [7:0] c_out;
  logic       c_ov;

  int checks = 0;
  int errors = 0;

  // Reference state: last accepted selection and whether it is current.
  logic [7:0] m_out;
  logic       m_val;

  typedef struct {
    logic sel;
    logic in1;
    logic in0;
    logic exp;
  } vec1_t;

  typedef struct {
    logic       sel;
    logic [7:0] in1;
    logic [7:0] in0;
    logic [7:0] exp;
  } vec8_t;

  always #5 clk = ~clk;

  mux2to1 #(.WIDTH(1), .REG_OUT(1'b1)) dut_w1 (
    .in1 (in1[0]), .in0 (in0[0]), .sel (sel), .out (w1_out),
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .out_valid (w1_ov)
  );

  mux2to1 #(.WIDTH(8), .REG_OUT(1'b1)) dut_w8 (
    .in1 (in1), .in0 (in0), .sel (sel), .out (w8_out),
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .out_valid (w8_ov)
  );

  mux2to1 #(.WIDTH(8), .REG_OUT(1'b0)) dut_c (
    .in1 (in1), .in0 (in0), .sel (sel), .out (c_out),
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .out_valid (c_ov)
  );

  function automatic logic [7:0] pick(input logic s, input logic [7:0] a, input logic [7:0] b);
    return s ? a : b;
  endfunction

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b, input logic v);
    sel      = s;
    in1      = a;
    in0      = b;
    in_valid = v;
  endtask

  // Combinational instance must already reflect the current inputs.
  task automatic comb_check();
    #1;
    chk8("comb_out", c_out, pick(sel, in1, in0));
    chk1("comb_valid", c_ov, in_valid & rst_n);
  endtask

  // One clock edge: advance the reference, then compare registered outputs.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (in_valid) begin
        m_out = pick(sel, in1, in0);
        m_val = 1'b1;
      end else begin
        m_val = 1'b0;
      end
    end
    #1;
    chk8("w8_out", w8_out, m_out);
    chk1("w8_valid", w8_ov, m_val);
    chk1("w1_out", w1_out, m_out[0]);
    chk1("w1_valid", w1_ov, m_val);
  endtask

  initial begin
    vec1_t v1[8];
    vec8_t v8[2];

    // Exhaustive 1-bit sweep: sel=0 gives in0, sel=1 gives in1.
    v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b0, 1'b1, 1'b1};
    v1[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    v1[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    v1[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    v1[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    v1[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    v1[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
    v8[0] = '{1'b0, 8'hA5, 8'h3C, 8'h3C};
    v8[1] = '{1'b1, 8'hA5, 8'h3C, 8'hA5};

    m_out = 8'h00;
    m_val = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);

    // Reset state
    #12;
    chk8("rst_w8_out", w8_out, 8'h00);
    chk1("rst_w8_valid", w8_ov, 1'b0);
    chk1("rst_w1_valid", w1_ov, 1'b0);
    in_valid = 1'b1;
    comb_check();
    in_valid = 1'b0;

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // 1-bit table
    for (int i = 0; i < 8; i++) begin
      drive(v1[i].sel, {7'b0, v1[i].in1}, {7'b0, v1[i].in0}, 1'b1);
      comb_check();
      tick();
      chk1("tbl1_out", w1_out, v1[i].exp);
      chk1("tbl1_valid", w1_ov, 1'b1);
    end

    // 8-bit table
    for (int i = 0; i < 2; i++) begin
      drive(v8[i].sel, v8[i].in1, v8[i].in0, 1'b1);
      comb_check();
      tick();
      chk8("tbl8_out", w8_out, v8[i].exp);
      chk1("tbl8_valid", w8_ov, 1'b1);
    end

    // One valid cycle then idle: data holds, valid drops.
    drive(1'b1, 8'hFF, 8'h00, 1'b1);
    tick();
    chk8("hold_first", w8_out, 8'hFF);
    chk1("hold_first_valid", w8_ov, 1'b1);
    drive(1'b0, 8'h12, 8'h34, 1'b0);
    tick();
    chk8("hold_out", w8_out, 8'hFF);
    chk1("hold_valid", w8_ov, 1'b0);
    tick();
    chk8("hold_out2", w8_out, 8'hFF);

    // Mid-cycle reset while out=A5 with another sample pending.
    drive(1'b1, 8'hA5, 8'h00, 1'b1);
    tick();
    chk8("pre_rst_out", w8_out, 8'hA5);
    drive(1'b0, 8'hFF, 8'h11, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk8("async_rst_out", w8_out, 8'h00);
    chk1("async_rst_valid", w8_ov, 1'b0);
    chk1("async_rst_comb_valid", c_ov, 1'b0);
    m_out = 8'h00;
    m_val = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk8("post_rst_out", w8_out, 8'h00);
    chk1("post_rst_valid", w8_ov, 1'b0);

    // Combinational instance follows sel without a clock edge.
    drive(1'b0, 8'h01, 8'h00, 1'b1);
    #1;
    chk8("comb_toggle0", c_out, 8'h00);
    for (int i = 0; i < 4; i++) begin
      sel = ~sel;
      #1;
      chk8("comb_toggle", c_out, {7'b0, sel});
    end
    tick();

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      comb_check();
      if ($urandom_range(0, 31) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        m_out = 8'h00;
        m_val = 1'b0;
        chk8("rnd_rst_out", w8_out, 8'h00);
        chk1("rnd_rst_valid", w8_ov, 1'b0);
        chk1("rnd_rst_comb_valid", c_ov, 1'b0);
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("test complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux2to1
